comp_pointer_bank: RTL and testbench
====================================

Name: comp_pointer_bank

Overview:
- Per-task, per-core circular-buffer pointer bank between the fingerprint generators (producers) and the fingerprint comparator (consumer).
- Parametrised successor of the two-core head/tail register file. It generalises core count and task count.
- It stores each task's start/end window internally instead of taking it on ports.
- It tracks occupancy per core, derives "fingerprints ready" from occupancy, and reports overflow/underflow with sticky error capture.

Parameters:
NUM_CORES, 2, logical cores producing fingerprints (>=2)
NUM_TASKS, 16, task slots per core
ADDR_W, 9, fingerprint RAM address width (matches CRC_RAM_ADDRESS_WIDTH)
TASK_W, $clog2(NUM_TASKS), task index width (derived)
CORE_W, $clog2(NUM_CORES), core index width (derived)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configure task window (level, held until cfg_ack)
cfg_task  in  TASK_W  task to configure
cfg_start  in  ADDR_W  first RAM address of task window
cfg_end  in  ADDR_W  last RAM address of task window (inclusive, >= cfg_start)
cfg_ack  out  1  one-cycle pulse, configuration done
inc_valid  in  1  producer wrote one fingerprint (level, held until inc_ack)
inc_core  in  CORE_W  producing core
inc_task  in  TASK_W  producing task
inc_ack  out  1  one-cycle pulse
fprint_head_pointer  out  ADDR_W  head[inc_core][inc_task], combinational
comp_task  in  TASK_W  task under comparison
comp_inc_tail  in  1  single-cycle strobe, advance all cores' tails of comp_task
comp_clear_req  in  1  flush request (level, held until comp_clear_ack)
comp_mismatch  in  1  qualifies comp_clear_req: 1 = flush task
comp_clear_ack  out  1  one-cycle pulse
comp_head_pointers  out  NUM_CORES*ADDR_W  head[c][comp_task], core 0 in LSBs
comp_tail_pointers  out  NUM_CORES*ADDR_W  tail[c][comp_task]
heads_match  out  1  all comp_head_pointers equal
tail_at_head  out  NUM_CORES  bit c: count[c][comp_task]==0
fprints_ready  out  NUM_TASKS  bit t: count[c][t]!=0 for every c
overflow_err  out  1  sticky; inc to a full slot
underflow_err  out  1  sticky; tail inc on an empty slot
err_core  out  CORE_W  core of first captured error
err_task  out  TASK_W  task of first captured error

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE. All start/end/head/tail = 0. All counts = 0. All acks 0, errors 0, err_core/err_task 0, fprints_ready 0.
- FSM states: IDLE, CFG, CFG_ACK, INC_ACK, CLR_ACK.
- IDLE priority: cfg_valid -> CFG; else inc_valid -> INC_ACK; else comp_clear_req -> CLR_ACK.
- CFG -> CFG_ACK -> IDLE. INC_ACK -> IDLE. CLR_ACK -> IDLE.
- Acks are asserted only in their state, so each ack is exactly one cycle. A request still high in the IDLE following its ack is a new request.
- CFG (state-entry cycle): for cfg_task and every core, set start=cfg_start, end=cfg_end, head=tail=cfg_start, count=0.
- INC_ACK, for the selected core/task:
  - If count < end-start+1: head = (head==end) ? start : head+1, and count+1.
  - Else (full): head unchanged; set overflow_err.
  - inc_ack pulses in both cases.
- comp_inc_tail is honoured in any cycle, independent of the FSM. For each core c, on comp_task:
  - If count>0: tail = (tail==end) ? start : tail+1, and count-1.
  - Else: tail unchanged; set underflow_err.
- Simultaneous events:
  - Head and tail advance on the same core/task in one cycle (INC_ACK + comp_inc_tail): both pointers move and count is unchanged. The full check uses the pre-cycle count, minus 1 if the tail also pops.
  - CFG or a flush of the same task overrides a coincident comp_inc_tail; the tail event is dropped silently.
- CLR_ACK:
  - If comp_mismatch=1: head=tail=start and count=0 for all cores of comp_task, so ready clears.
  - Else: no state change (ready is derived from count).
- Errors: err_core/err_task are captured only when both flags were 0 before the event. Flags clear only on reset.
  - For underflow, err_core is the lowest-index core that underflowed.
- Count width is ADDR_W+1 so that a window spanning the whole RAM is representable.
- Pointer arithmetic is ADDR_W wide. Wrap occurs only at the configured end; end==start is a 1-entry window.
- All comparator outputs are combinational from flops, zero latency. Storage is flops, not RAM.

Decomposition:
- Shared package crc_pkg:
  - FSM state enum.
  - ptr_t (ADDR_W).
  - Constants NUM_CORES_DEF and NUM_TASKS_DEF.
  - Function next_ptr(p, start, end).
- Sub-module comp_pointer_slot: one core's head/tail/count/start/end for all tasks, plus full/empty logic. Instantiated NUM_CORES times via generate.

Test Plan:
- Reset mid-INC_ACK (reset_n low 1 cycle) -> all outputs 0, FSM IDLE, no inc_ack next cycle.
- cfg task 3 start=0x010 end=0x012; 3 incs on core0 and core1 -> heads 0x011, 0x012, 0x010 (wrap); fprints_ready[3]=1 after first inc on both cores; heads_match=1.
- After 3 incs on core0 (full), a 4th inc -> inc_ack pulses, head stays 0x010, overflow_err=1, err_core=0, err_task=3.
- Core0 count=1 core1 count=0 on task 3, comp_inc_tail -> core0 tail advances, core1 tail unchanged, underflow_err=1, err_core=1.
- INC_ACK (core0, task 5, count=2) coincident with comp_inc_tail on task 5 -> core0 head and tail both +1, count stays 2.
- comp_clear_req with comp_mismatch=1 on task 3 -> comp_clear_ack one cycle, head=tail=0x010 all cores, fprints_ready[3]=0; same with mismatch=0 -> ack, pointers unchanged.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the fingerprint pointer bank.
//   bank_state_e : handshake FSM states
//   ptr_t        : fingerprint RAM address
//   next_ptr     : circular advance inside a [start, last] window
package crc_pkg;

  localparam int unsigned NUM_CORES_DEF = 2;
  localparam int unsigned NUM_TASKS_DEF = 16;
  localparam int unsigned ADDR_W_DEF    = 9;

  typedef logic [ADDR_W_DEF-1:0] ptr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_CFG_ACK,
    ST_INC_ACK,
    ST_CLR_ACK
  } bank_state_e;

  // Wrap happens only at the configured last address; start==last is a
  // single-entry window that always returns to start.
  function automatic ptr_t next_ptr(input ptr_t p, input ptr_t start, input ptr_t last);
    return (p == last) ? start : ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/comp_pointer_slot.sv
// One core's pointer state for every task: window start/last, head, tail
// and occupancy count, with the full/empty decisions for that core.
//   cfg_en/cfg_task/cfg_start/cfg_end : load a task window, empty it
//   inc_en/inc_task                   : producer push on this core
//   tail_en/comp_task                 : consumer pop on comp_task
//   flush_en                          : empty comp_task (mismatch flush)
//   inc_head/comp_head/comp_tail      : pointer read-out
//   nonempty                          : bit t set when count[t] != 0
//   overflow/underflow                : single-cycle error events
module comp_pointer_slot
  import crc_pkg::*;
#(
  parameter int unsigned NUM_TASKS = NUM_TASKS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned TASK_W    = $clog2(NUM_TASKS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_en,
  input  logic [TASK_W-1:0]    cfg_task,
  input  logic [ADDR_W-1:0]    cfg_start,
  input  logic [ADDR_W-1:0]    cfg_end,
  input  logic                 inc_en,
  input  logic [TASK_W-1:0]    inc_task,
  input  logic                 tail_en,
  input  logic                 flush_en,
  input  logic [TASK_W-1:0]    comp_task,
  output logic [ADDR_W-1:0]    inc_head,
  output logic [ADDR_W-1:0]    comp_head,
  output logic [ADDR_W-1:0]    comp_tail,
  output logic [NUM_TASKS-1:0] nonempty,
  output logic                 overflow,
  output logic                 underflow
);

  // One extra bit so a window covering the whole RAM can be completely full.
  typedef logic [ADDR_W:0] cnt_t;

  logic [ADDR_W-1:0] start_q [NUM_TASKS];
  logic [ADDR_W-1:0] start_d [NUM_TASKS];
  logic [ADDR_W-1:0] last_q  [NUM_TASKS];
  logic [ADDR_W-1:0] last_d  [NUM_TASKS];
  logic [ADDR_W-1:0] head_q  [NUM_TASKS];
  logic [ADDR_W-1:0] head_d  [NUM_TASKS];
  logic [ADDR_W-1:0] tail_q  [NUM_TASKS];
  logic [ADDR_W-1:0] tail_d  [NUM_TASKS];
  cnt_t              count_q [NUM_TASKS];
  cnt_t              count_d [NUM_TASKS];

  logic tail_live;
  logic pop;
  logic push;
  cnt_t occ;
  cnt_t win;

  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] p,
                                                input logic [ADDR_W-1:0] s,
                                                input logic [ADDR_W-1:0] e);
    return ADDR_W'(next_ptr(ptr_t'(p), ptr_t'(s), ptr_t'(e)));
  endfunction

  always_comb begin
    // A configure or flush of the task being popped wins; the pop is dropped
    // without raising underflow. Flush always targets comp_task.
    tail_live = tail_en && !flush_en && !(cfg_en && (cfg_task == comp_task));
    pop       = tail_live && (count_q[comp_task] != '0);
    underflow = tail_live && (count_q[comp_task] == '0);
    win       = {1'b0, last_q[inc_task]} - {1'b0, start_q[inc_task]} + cnt_t'(1);
    // A same-cycle pop on the same task frees a slot before the full check.
    occ       = count_q[inc_task] - cnt_t'(pop && (comp_task == inc_task));
    push      = inc_en && (occ < win);
    overflow  = inc_en && !push;
  end

  always_comb begin
    start_d = start_q;
    last_d  = last_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      tail_d[comp_task]  = advance(tail_q[comp_task], start_q[comp_task], last_q[comp_task]);
      count_d[comp_task] = count_d[comp_task] - cnt_t'(1);
    end
    if (push) begin
      head_d[inc_task]  = advance(head_q[inc_task], start_q[inc_task], last_q[inc_task]);
      count_d[inc_task] = count_d[inc_task] + cnt_t'(1);
    end
    if (flush_en) begin
      head_d[comp_task]  = start_q[comp_task];
      tail_d[comp_task]  = start_q[comp_task];
      count_d[comp_task] = '0;
    end
    if (cfg_en) begin
      start_d[cfg_task] = cfg_start;
      last_d[cfg_task]  = cfg_end;
      head_d[cfg_task]  = cfg_start;
      tail_d[cfg_task]  = cfg_start;
      count_d[cfg_task] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned t = 0; t < NUM_TASKS; t++) begin
        start_q[t] <= '0;
        last_q[t]  <= '0;
        head_q[t]  <= '0;
        tail_q[t]  <= '0;
        count_q[t] <= '0;
      end
    end else begin
      start_q <= start_d;
      last_q  <= last_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    inc_head  = head_q[inc_task];
    comp_head = head_q[comp_task];
    comp_tail = tail_q[comp_task];
    nonempty  = '0;
    for (int unsigned t = 0; t < NUM_TASKS; t++) begin
      nonempty[t] = (count_q[t] != '0);
    end
  end

endmodule

// File: rtl/comp_pointer_bank.sv
// Per-task, per-core circular-buffer pointer bank between the fingerprint
// generators and the fingerprint comparator.
//   cfg_*            : task window configuration handshake
//   inc_*            : producer write handshake, fprint_head_pointer read-out
//   comp_task        : task viewed/advanced by the comparator
//   comp_inc_tail    : pop one entry of comp_task on every core (any cycle)
//   comp_clear_*     : flush handshake, comp_mismatch selects a real flush
//   comp_*_pointers  : per-core head/tail of comp_task, core 0 in LSBs
//   heads_match, tail_at_head, fprints_ready : occupancy-derived status
//   overflow_err, underflow_err, err_core, err_task : sticky error capture
module comp_pointer_bank
  import crc_pkg::*;
#(
  parameter int unsigned NUM_CORES = NUM_CORES_DEF,
  parameter int unsigned NUM_TASKS = NUM_TASKS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned TASK_W    = $clog2(NUM_TASKS),
  parameter int unsigned CORE_W    = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cfg_valid,
  input  logic [TASK_W-1:0]           cfg_task,
  input  logic [ADDR_W-1:0]           cfg_start,
  input  logic [ADDR_W-1:0]           cfg_end,
  output logic                        cfg_ack,
  input  logic                        inc_valid,
  input  logic [CORE_W-1:0]           inc_core,
  input  logic [TASK_W-1:0]           inc_task,
  output logic                        inc_ack,
  output logic [ADDR_W-1:0]           fprint_head_pointer,
  input  logic [TASK_W-1:0]           comp_task,
  input  logic                        comp_inc_tail,
  input  logic                        comp_clear_req,
  input  logic                        comp_mismatch,
  output logic                        comp_clear_ack,
  output logic [NUM_CORES*ADDR_W-1:0] comp_head_pointers,
  output logic [NUM_CORES*ADDR_W-1:0] comp_tail_pointers,
  output logic                        heads_match,
  output logic [NUM_CORES-1:0]        tail_at_head,
  output logic [NUM_TASKS-1:0]        fprints_ready,
  output logic                        overflow_err,
  output logic                        underflow_err,
  output logic [CORE_W-1:0]           err_core,
  output logic [TASK_W-1:0]           err_task
);

  bank_state_e state_q, state_d;

  logic cfg_en;
  logic inc_active;
  logic flush_en;

  logic [ADDR_W-1:0]    inc_head_v [NUM_CORES];
  logic [NUM_TASKS-1:0] nonempty_v [NUM_CORES];
  logic [NUM_CORES-1:0] ovf_v;
  logic [NUM_CORES-1:0] unf_v;

  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;
  logic [CORE_W-1:0] err_core_q,  err_core_d;
  logic [TASK_W-1:0] err_task_q,  err_task_d;
  logic [CORE_W-1:0] unf_core;
  logic              unf_found;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid)           state_d = ST_CFG;
        else if (inc_valid)      state_d = ST_INC_ACK;
        else if (comp_clear_req) state_d = ST_CLR_ACK;
      end
      ST_CFG:     state_d = ST_CFG_ACK;
      ST_CFG_ACK: state_d = ST_IDLE;
      ST_INC_ACK: state_d = ST_IDLE;
      ST_CLR_ACK: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ack        = (state_q == ST_CFG_ACK);
    inc_ack        = (state_q == ST_INC_ACK);
    comp_clear_ack = (state_q == ST_CLR_ACK);
    cfg_en         = (state_q == ST_CFG);
    inc_active     = (state_q == ST_INC_ACK);
    flush_en       = (state_q == ST_CLR_ACK) && comp_mismatch;
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_slot
    comp_pointer_slot #(
      .NUM_TASKS (NUM_TASKS),
      .ADDR_W    (ADDR_W),
      .TASK_W    (TASK_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_en    (cfg_en),
      .cfg_task  (cfg_task),
      .cfg_start (cfg_start),
      .cfg_end   (cfg_end),
      .inc_en    (inc_active && (inc_core == CORE_W'(c))),
      .inc_task  (inc_task),
      .tail_en   (comp_inc_tail),
      .flush_en  (flush_en),
      .comp_task (comp_task),
      .inc_head  (inc_head_v[c]),
      .comp_head (comp_head_pointers[c*ADDR_W +: ADDR_W]),
      .comp_tail (comp_tail_pointers[c*ADDR_W +: ADDR_W]),
      .nonempty  (nonempty_v[c]),
      .overflow  (ovf_v[c]),
      .underflow (unf_v[c])
    );
  end

  always_comb begin
    fprint_head_pointer = inc_head_v[inc_core];
    fprints_ready       = '1;
    heads_match         = 1'b1;
    tail_at_head        = '0;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      fprints_ready   = fprints_ready & nonempty_v[c];
      tail_at_head[c] = !nonempty_v[c][comp_task];
      if (comp_head_pointers[c*ADDR_W +: ADDR_W] != comp_head_pointers[ADDR_W-1:0]) begin
        heads_match = 1'b0;
      end
    end
  end

  // Error capture. If overflow and underflow first appear in the same cycle,
  // the overflow's core/task is the one recorded.
  always_comb begin
    unf_core  = '0;
    unf_found = 1'b0;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (unf_v[c] && !unf_found) begin
        unf_core  = CORE_W'(c);
        unf_found = 1'b1;
      end
    end
    err_core_d = err_core_q;
    err_task_d = err_task_q;
    if (!overflow_q && !underflow_q) begin
      if (|ovf_v) begin
        err_core_d = inc_core;
        err_task_d = inc_task;
      end else if (|unf_v) begin
        err_core_d = unf_core;
        err_task_d = comp_task;
      end
    end
    overflow_d  = overflow_q  | (|ovf_v);
    underflow_d = underflow_q | (|unf_v);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      err_core_q  <= '0;
      err_task_q  <= '0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      err_core_q  <= err_core_d;
      err_task_q  <= err_task_d;
    end
  end

  always_comb begin
    overflow_err  = overflow_q;
    underflow_err = underflow_q;
    err_core      = err_core_q;
    err_task      = err_task_q;
  end

endmodule

// File: tb/tb_comp_pointer_bank.sv
module tb_comp_pointer_bank;

  localparam int NC = 2;
  localparam int NT = 16;
  localparam int AW = 9;
  localparam int TW = 4;
  localparam int CW = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cfg_valid;
  logic [TW-1:0]    cfg_task;
  logic [AW-1:0]    cfg_start;
  logic [AW-1:0]    cfg_end;
  logic             cfg_ack;
  logic             inc_valid;
  logic [CW-1:0]    inc_core;
  logic [TW-1:0]    inc_task;
  logic             inc_ack;
  logic [AW-1:0]    fprint_head_pointer;
  logic [TW-1:0]    comp_task;
  logic             comp_inc_tail;
  logic             comp_clear_req;
  logic             comp_mismatch;
  logic             comp_clear_ack;
  logic [NC*AW-1:0] comp_head_pointers;
  logic [NC*AW-1:0] comp_tail_pointers;
  logic             heads_match;
  logic [NC-1:0]    tail_at_head;
  logic [NT-1:0]    fprints_ready;
  logic             overflow_err;
  logic             underflow_err;
  logic [CW-1:0]    err_core;
  logic [TW-1:0]    err_task;

  always #5 clk = ~clk;

  comp_pointer_bank #(
    .NUM_CORES (NC),
    .NUM_TASKS (NT),
    .ADDR_W    (AW)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cfg_valid           (cfg_valid),
    .cfg_task            (cfg_task),
    .cfg_start           (cfg_start),
    .cfg_end             (cfg_end),
    .cfg_ack             (cfg_ack),
    .inc_valid           (inc_valid),
    .inc_core            (inc_core),
    .inc_task            (inc_task),
    .inc_ack             (inc_ack),
    .fprint_head_pointer (fprint_head_pointer),
    .comp_task           (comp_task),
    .comp_inc_tail       (comp_inc_tail),
    .comp_clear_req      (comp_clear_req),
    .comp_mismatch       (comp_mismatch),
    .comp_clear_ack      (comp_clear_ack),
    .comp_head_pointers  (comp_head_pointers),
    .comp_tail_pointers  (comp_tail_pointers),
    .heads_match         (heads_match),
    .tail_at_head        (tail_at_head),
    .fprints_ready       (fprints_ready),
    .overflow_err        (overflow_err),
    .underflow_err       (underflow_err),
    .err_core            (err_core),
    .err_task            (err_task)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer windows, pointers and occupancies.
  int m_start [NC][NT];
  int m_last  [NC][NT];
  int m_head  [NC][NT];
  int m_tail  [NC][NT];
  int m_cnt   [NC][NT];
  bit m_ovf;
  bit m_unf;
  int m_ecore;
  int m_etask;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int t = 0; t < NT; t++) begin
        m_start[c][t] = 0; m_last[c][t] = 0;
        m_head[c][t]  = 0; m_tail[c][t] = 0; m_cnt[c][t] = 0;
      end
    end
    m_ovf = 0; m_unf = 0; m_ecore = 0; m_etask = 0;
  endtask

  function automatic int adv(input int p, input int s, input int e);
    return s + ((p - s + 1) % (e - s + 1));
  endfunction

  // One clock's worth of events, applied in the order the rules imply.
  task automatic model_cycle(input bit ev_cfg, input int ct, input int cs, input int ce,
                             input bit ev_inc, input int ic, input int it,
                             input bit ev_flush, input bit ev_tail, input int tt);
    int low = -1;
    bit ovf_hit = 0;
    if (ev_tail && !(ev_cfg && ct == tt) && !ev_flush) begin
      for (int c = 0; c < NC; c++) begin
        if (m_cnt[c][tt] > 0) begin
          m_tail[c][tt] = adv(m_tail[c][tt], m_start[c][tt], m_last[c][tt]);
          m_cnt[c][tt]--;
        end else if (low < 0) begin
          low = c;
        end
      end
    end
    if (ev_inc) begin
      if (m_cnt[ic][it] < m_last[ic][it] - m_start[ic][it] + 1) begin
        m_head[ic][it] = adv(m_head[ic][it], m_start[ic][it], m_last[ic][it]);
        m_cnt[ic][it]++;
      end else begin
        ovf_hit = 1;
      end
    end
    if (ev_flush) begin
      for (int c = 0; c < NC; c++) begin
        m_head[c][tt] = m_start[c][tt]; m_tail[c][tt] = m_start[c][tt]; m_cnt[c][tt] = 0;
      end
    end
    if (ev_cfg) begin
      for (int c = 0; c < NC; c++) begin
        m_start[c][ct] = cs; m_last[c][ct] = ce;
        m_head[c][ct] = cs; m_tail[c][ct] = cs; m_cnt[c][ct] = 0;
      end
    end
    if (!m_ovf && !m_unf) begin
      if (ovf_hit) begin m_ecore = ic; m_etask = it; end
      else if (low >= 0) begin m_ecore = low; m_etask = tt; end
    end
    m_ovf = m_ovf | ovf_hit;
    m_unf = m_unf | (low >= 0);
  endtask

  task automatic look(input int t);
    comp_task = TW'(t);
    #1;
  endtask

  task automatic check_all(input int ct);
    logic [NC*AW-1:0] eh;
    logic [NC*AW-1:0] et;
    logic [NC-1:0]    etah;
    logic [NT-1:0]    erdy;
    bit               ehm;
    int               rc;
    int               rt;
    look(ct);
    ehm = 1;
    for (int c = 0; c < NC; c++) begin
      eh[c*AW +: AW] = AW'(m_head[c][ct]);
      et[c*AW +: AW] = AW'(m_tail[c][ct]);
      etah[c] = (m_cnt[c][ct] == 0);
      if (m_head[c][ct] != m_head[0][ct]) ehm = 0;
    end
    for (int t = 0; t < NT; t++) begin
      erdy[t] = 1'b1;
      for (int c = 0; c < NC; c++) if (m_cnt[c][t] == 0) erdy[t] = 1'b0;
    end
    check_eq("heads",         64'(comp_head_pointers), 64'(eh));
    check_eq("tails",         64'(comp_tail_pointers), 64'(et));
    check_eq("heads_match",   64'(heads_match),        64'(ehm));
    check_eq("tail_at_head",  64'(tail_at_head),       64'(etah));
    check_eq("fprints_ready", 64'(fprints_ready),      64'(erdy));
    check_eq("overflow_err",  64'(overflow_err),       64'(m_ovf));
    check_eq("underflow_err", 64'(underflow_err),      64'(m_unf));
    check_eq("err_core",      64'(err_core),           64'(m_ecore));
    check_eq("err_task",      64'(err_task),           64'(m_etask));
    rc = $urandom_range(0, NC-1);
    rt = $urandom_range(0, NT-1);
    inc_core = CW'(rc); inc_task = TW'(rt);
    #1;
    check_eq("fprint_head", 64'(fprint_head_pointer), 64'(m_head[rc][rt]));
  endtask

  task automatic do_cfg(input int t, input int s, input int e, input bit tail_too, input int tt);
    cfg_valid = 1'b1; cfg_task = TW'(t); cfg_start = AW'(s); cfg_end = AW'(e);
    @(negedge clk);
    if (tail_too) begin comp_task = TW'(tt); comp_inc_tail = 1'b1; end
    @(negedge clk);
    comp_inc_tail = 1'b0;
    model_cycle(1, t, s, e, 0, 0, 0, 0, tail_too, tt);
    check_eq("cfg_ack", 64'(cfg_ack), 64'd1);
    cfg_valid = 1'b0;
    @(negedge clk);
    check_eq("cfg_ack_pulse", 64'(cfg_ack), 64'd0);
  endtask

  task automatic do_inc(input int c, input int t, input bit tail_too, input int tt);
    inc_valid = 1'b1; inc_core = CW'(c); inc_task = TW'(t);
    @(negedge clk);
    check_eq("inc_ack", 64'(inc_ack), 64'd1);
    check_eq("fprint_head_pre", 64'(fprint_head_pointer), 64'(m_head[c][t]));
    inc_valid = 1'b0;
    if (tail_too) begin comp_task = TW'(tt); comp_inc_tail = 1'b1; end
    @(negedge clk);
    comp_inc_tail = 1'b0;
    model_cycle(0, 0, 0, 0, 1, c, t, 0, tail_too, tt);
    check_eq("inc_ack_pulse", 64'(inc_ack), 64'd0);
  endtask

  task automatic do_tail(input int tt);
    comp_task = TW'(tt); comp_inc_tail = 1'b1;
    @(negedge clk);
    comp_inc_tail = 1'b0;
    model_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, tt);
  endtask

  task automatic do_clr(input int t, input bit mm, input bit tail_too);
    comp_clear_req = 1'b1; comp_mismatch = mm; comp_task = TW'(t);
    @(negedge clk);
    check_eq("clr_ack", 64'(comp_clear_ack), 64'd1);
    comp_clear_req = 1'b0;
    if (tail_too) comp_inc_tail = 1'b1;
    @(negedge clk);
    comp_inc_tail = 1'b0;
    comp_mismatch = 1'b0;
    model_cycle(0, 0, 0, 0, 0, 0, 0, mm, tail_too, t);
    check_eq("clr_ack_pulse", 64'(comp_clear_ack), 64'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_valid = 1'b0; cfg_task = '0; cfg_start = '0; cfg_end = '0;
    inc_valid = 1'b0; inc_core = '0; inc_task = '0;
    comp_task = '0; comp_inc_tail = 1'b0; comp_clear_req = 1'b0; comp_mismatch = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst_cfg_ack", 64'(cfg_ack), 64'd0);
    check_eq("rst_inc_ack", 64'(inc_ack), 64'd0);
    check_eq("rst_clr_ack", 64'(comp_clear_ack), 64'd0);
    check_all(0);

    // Reset asserted while INC_ACK is active
    do_cfg(3, 'h010, 'h012, 0, 0);
    inc_valid = 1'b1; inc_core = '0; inc_task = TW'(3);
    @(negedge clk);
    check_eq("mid_inc_ack", 64'(inc_ack), 64'd1);
    reset_n = 1'b0; inc_valid = 1'b0;
    #1;
    check_eq("async_rst_ack", 64'(inc_ack), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ack", 64'(inc_ack), 64'd0);
    check_all(3);

    // Window 0x010..0x012, fill both cores, wrap, then overflow core 0
    do_cfg(3, 'h010, 'h012, 0, 0);
    do_inc(0, 3, 0, 0);
    look(3);
    check_eq("ready_one_core", 64'(fprints_ready[3]), 64'd0);
    do_inc(1, 3, 0, 0);
    look(3);
    check_eq("ready_both", 64'(fprints_ready[3]), 64'd1);
    check_eq("heads_011", 64'(comp_head_pointers), 64'h02211);
    do_inc(0, 3, 0, 0); do_inc(1, 3, 0, 0);
    do_inc(0, 3, 0, 0); do_inc(1, 3, 0, 0);
    look(3);
    check_eq("heads_wrap", 64'(comp_head_pointers), 64'h02010);
    check_eq("match_wrap", 64'(heads_match), 64'd1);
    check_all(3);
    do_inc(0, 3, 0, 0);
    look(3);
    check_eq("ovf_head", 64'(comp_head_pointers[AW-1:0]), 64'h010);
    check_eq("ovf_flag", 64'(overflow_err), 64'd1);
    check_eq("ovf_core", 64'(err_core), 64'd0);
    check_eq("ovf_task", 64'(err_task), 64'd3);
    check_all(3);

    // Underflow on core 1 only
    pulse_reset();
    do_cfg(3, 'h010, 'h012, 0, 0);
    do_inc(0, 3, 0, 0);
    do_tail(3);
    look(3);
    check_eq("unf_tails", 64'(comp_tail_pointers), 64'h02011);
    check_eq("unf_flag", 64'(underflow_err), 64'd1);
    check_eq("unf_core", 64'(err_core), 64'd1);
    check_eq("unf_task", 64'(err_task), 64'd3);
    check_all(3);

    // Coincident push and pop on task 5, then on a full 2-entry window
    do_cfg(5, 'h100, 'h107, 0, 0);
    do_inc(0, 5, 0, 0); do_inc(0, 5, 0, 0);
    do_inc(0, 5, 1, 5);
    look(5);
    check_eq("co_head", 64'(comp_head_pointers[AW-1:0]), 64'h103);
    check_eq("co_tail", 64'(comp_tail_pointers[AW-1:0]), 64'h101);
    check_eq("co_cnt_nz", 64'(tail_at_head[0]), 64'd0);
    check_all(5);
    do_cfg(6, 'h1fe, 'h1ff, 0, 0);
    do_inc(0, 6, 0, 0); do_inc(0, 6, 0, 0);
    do_inc(0, 6, 1, 6);
    check_all(6);
    do_cfg(7, 'h1ff, 'h1ff, 0, 0);
    do_inc(1, 7, 0, 0); do_inc(1, 7, 0, 0);
    check_all(7);

    // Flush with and without mismatch, and a flush overriding a tail pop
    do_cfg(3, 'h010, 'h012, 0, 0);
    do_inc(0, 3, 0, 0); do_inc(1, 3, 0, 0); do_inc(0, 3, 0, 0);
    do_clr(3, 1, 0);
    look(3);
    check_eq("flush_heads", 64'(comp_head_pointers), 64'h02010);
    check_eq("flush_tails", 64'(comp_tail_pointers), 64'h02010);
    check_eq("flush_ready", 64'(fprints_ready[3]), 64'd0);
    check_all(3);
    do_inc(0, 3, 0, 0); do_inc(1, 3, 0, 0);
    do_clr(3, 0, 0);
    check_all(3);
    do_clr(3, 1, 1);
    check_all(3);
    do_cfg(4, 'h020, 'h023, 0, 0);
    do_inc(0, 4, 0, 0); do_inc(1, 4, 0, 0);
    do_cfg(4, 'h030, 'h031, 1, 4);
    check_all(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      int t;
      int tt;
      op = $urandom_range(0, 9);
      t  = $urandom_range(0, NT-1);
      tt = ($urandom_range(0, 1) == 0) ? t : $urandom_range(0, NT-1);
      if (op == 0) begin
        int len;
        int s;
        len = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 6);
        s   = $urandom_range(0, 512 - len);
        do_cfg(t, s, s + len - 1, $urandom_range(0, 2) == 0, tt);
      end else if (op <= 5) begin
        do_inc($urandom_range(0, NC-1), t, $urandom_range(0, 2) == 0, tt);
      end else if (op <= 7) begin
        do_tail(t);
      end else begin
        do_clr(t, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      end
      check_all($urandom_range(0, NT-1));
      if (i == 200) begin
        pulse_reset();
        check_all(t);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
